// File: rtl/addsub_arb_pkg.sv
// rtl/addsub_arb_pkg.sv - shared constants and helpers for the adder-subtractor arbiter
package addsub_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int DEF_N    = 8;
    localparam int DEF_NREQ = 4;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/AdderSubtractor_GateLevel.sv
// rtl/AdderSubtractor_GateLevel.sv - ripple-carry adder-subtractor built from gate primitives
module AdderSubtractor_GateLevel #(
    parameter int N = 8
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         mode,
    output logic [N-1:0] S,
    output logic         Cout
);

    logic [N:0]   c;
    logic [N-1:0] bx;

    // Subtract inverts B and injects the +1 through the carry-in.
    assign c[0] = mode;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign bx[i]  = B[i] ^ mode;
        assign S[i]   = A[i] ^ bx[i] ^ c[i];
        assign c[i+1] = (A[i] & bx[i]) | (c[i] & (A[i] ^ bx[i]));
    end

    assign Cout = c[N];

endmodule

// File: rtl/addsub_rr_picker.sv
// rtl/addsub_rr_picker.sv - combinational round-robin pick starting at ptr
module addsub_rr_picker #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    logic [IDW-1:0] hi_idx;
    logic [IDW-1:0] lo_idx;
    logic           hi_found;

    // Lowest valid at or above ptr wins; otherwise wrap to the lowest valid overall.
    always_comb begin
        hi_idx   = '0;
        lo_idx   = '0;
        hi_found = 1'b0;
        any      = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_idx = IDW'(i);
                any    = 1'b1;
                if (IDW'(i) >= ptr) begin
                    hi_idx   = IDW'(i);
                    hi_found = 1'b1;
                end
            end
        end
        idx   = hi_found ? hi_idx : lo_idx;
        grant = any ? (NREQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/addsub_arbiter.sv
// rtl/addsub_arbiter.sv - round-robin sequencer sharing one adder-subtractor; ADDSUB_ARB_OVF_EN adds rsp_ovf
module addsub_arbiter
    import addsub_arb_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int NREQ = DEF_NREQ,
    localparam int IDW = id_width(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    input  logic [NREQ-1:0]   req_mode,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [N-1:0]      rsp_s,
    output logic              rsp_cout
`ifdef ADDSUB_ARB_OVF_EN
    ,
    output logic              rsp_ovf
`endif
);

    logic [1:0]      state;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  ptr_next;
    logic [IDW-1:0]  pick_idx;
    logic [NREQ-1:0] pick_grant;
    logic            pick_any;
    logic            accept_en;
    logic            take;

    logic [N-1:0]    op_a;
    logic [N-1:0]    op_b;
    logic            op_mode;
    logic [IDW-1:0]  op_id;
    logic [N-1:0]    sum;
    logic            cout;

    logic [N-1:0]    a_arr [NREQ];
    logic [N-1:0]    b_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign a_arr[g] = req_a[g*N +: N];
        assign b_arr[g] = req_b[g*N +: N];
    end

    addsub_rr_picker #(.NREQ(NREQ), .IDW(IDW)) u_picker (
        .req_valid (req_valid),
        .ptr       (ptr),
        .grant     (pick_grant),
        .idx       (pick_idx),
        .any       (pick_any)
    );

    AdderSubtractor_GateLevel #(.N(N)) u_addsub (
        .A    (op_a),
        .B    (op_b),
        .mode (op_mode),
        .S    (sum),
        .Cout (cout)
    );

    // A new request may be taken in the same cycle a response completes.
    assign accept_en = (state == ST_IDLE) || ((state == ST_RESP) && rsp_ready);
    assign req_ready = accept_en ? pick_grant : '0;
    assign take      = accept_en && pick_any;
    assign rsp_valid = (state == ST_RESP);
    assign ptr_next  = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            op_a     <= '0;
            op_b     <= '0;
            op_mode  <= 1'b0;
            op_id    <= '0;
            rsp_s    <= '0;
            rsp_cout <= 1'b0;
            rsp_id   <= '0;
        end else begin
            if (take) begin
                op_a    <= a_arr[pick_idx];
                op_b    <= b_arr[pick_idx];
                op_mode <= req_mode[pick_idx];
                op_id   <= pick_idx;
                ptr     <= ptr_next;
            end
            case (state)
                ST_IDLE: if (take) state <= ST_EXEC;
                ST_EXEC: begin
                    rsp_s    <= sum;
                    rsp_cout <= cout;
                    rsp_id   <= op_id;
                    state    <= ST_RESP;
                end
                ST_RESP: if (rsp_ready) state <= take ? ST_EXEC : ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ADDSUB_ARB_OVF_EN
    logic [N-1:0] b_eff;
    assign b_eff = op_b ^ {N{op_mode}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_ovf <= 1'b0;
        end else if (state == ST_EXEC) begin
            rsp_ovf <= (op_a[N-1] == b_eff[N-1]) && (sum[N-1] != op_a[N-1]);
        end
    end
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb/tb_addsub_arbiter.sv - directed self-checking bench for addsub_arbiter (ADDSUB_ARB_OVF_EN optional)
module tb_addsub_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_mode;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_s;
    logic        rsp_cout;
`ifdef ADDSUB_ARB_OVF_EN
    logic        rsp_ovf;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    addsub_arbiter #(.N(8), .NREQ(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_mode  (req_mode),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_s     (rsp_s),
        .rsp_cout  (rsp_cout)
`ifdef ADDSUB_ARB_OVF_EN
        ,
        .rsp_ovf   (rsp_ovf)
`endif
    );

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Issues one request and leaves the bench sampling in the RESP cycle; ok=0 on wrong latency.
    task automatic single_op(input int id, input logic [7:0] a, input logic [7:0] b,
                             input logic m, output bit ok);
        int n;
        ok = 1'b1;
        req_a[id*8 +: 8] = a;
        req_b[id*8 +: 8] = b;
        req_mode[id]     = m;
        req_valid[id]    = 1'b1;
        #1;
        n = 0;
        while (!req_ready[id] && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!req_ready[id]) ok = 1'b0;
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
        if (rsp_valid) ok = 1'b0;
        @(posedge clk);
        #1;
        if (!rsp_valid) ok = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        req_mode = '0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if ({req_ready, rsp_valid, rsp_id, rsp_s, rsp_cout} !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h required 0", {req_ready, rsp_valid, rsp_id, rsp_s, rsp_cout});
        end
`ifdef ADDSUB_ARB_OVF_EN
        tests_run++;
        if (rsp_ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ovf: got %b required 0", rsp_ovf);
        end
`endif
        do_reset();
    endtask

    task automatic test_single_add();
        bit ok;
        single_op(0, 8'd1, 8'd2, 1'b0, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL add_latency: got %b required 1", ok); end
        tests_run++;
        if (rsp_s !== 8'd3) begin tests_failed++; $display("FAIL add_s: got %0d required 3", rsp_s); end
        tests_run++;
        if (rsp_cout !== 1'b0) begin tests_failed++; $display("FAIL add_cout: got %b required 0", rsp_cout); end
        tests_run++;
        if (rsp_id !== 2'd0) begin tests_failed++; $display("FAIL add_id: got %0d required 0", rsp_id); end
        @(posedge clk);
        #1;
        tests_run++;
        if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL add_rsp_done: got %b required 0", rsp_valid); end
    endtask

    task automatic test_subtract();
        logic [7:0] va [3] = '{8'd4, 8'd255, 8'd170};
        logic [7:0] vb [3] = '{8'd10, 8'd1, 8'd170};
        logic [7:0] vs [3] = '{8'hFA, 8'd254, 8'd0};
        logic       vc [3] = '{1'b0, 1'b1, 1'b1};
        bit ok;
        for (int k = 0; k < 3; k++) begin
            single_op(2, va[k], vb[k], 1'b1, ok);
            tests_run++;
            if (!ok || rsp_id !== 2'd2) begin
                tests_failed++;
                $display("FAIL sub_%0d_id: got ok=%b id=%0d required ok=1 id=2", k, ok, rsp_id);
            end
            tests_run++;
            if (rsp_s !== vs[k]) begin tests_failed++; $display("FAIL sub_%0d_s: got %h required %h", k, rsp_s, vs[k]); end
            tests_run++;
            if (rsp_cout !== vc[k]) begin tests_failed++; $display("FAIL sub_%0d_cout: got %b required %b", k, rsp_cout, vc[k]); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_round_robin();
        int gcyc [10];
        int gid  [10];
        int rcyc [10];
        int rid  [10];
        int rs   [10];
        int gn = 0;
        int rn = 0;
        int exp_gid [5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_a[i*8 +: 8] = 8'(i);
            req_b[i*8 +: 8] = 8'd1;
            req_mode[i] = 1'b0;
        end
        req_valid = 4'b1111;
        #1;
        for (int cyc = 0; cyc < 9; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (req_ready[i]) begin gcyc[gn] = cyc; gid[gn] = i; gn++; end
            end
            if (rsp_valid && rsp_ready) begin
                rcyc[rn] = cyc; rid[rn] = int'(rsp_id); rs[rn] = int'(rsp_s); rn++;
            end
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        tests_run++;
        if (gn !== 5 || rn !== 4) begin
            tests_failed++;
            $display("FAIL rr_counts: got grants=%0d rsps=%0d required 5 and 4", gn, rn);
        end else begin
            for (int k = 0; k < 5; k++) begin
                tests_run++;
                if (gid[k] !== exp_gid[k] || gcyc[k] !== 2 * k) begin
                    tests_failed++;
                    $display("FAIL rr_grant_%0d: got id=%0d cyc=%0d required id=%0d cyc=%0d", k, gid[k], gcyc[k], exp_gid[k], 2 * k);
                end
            end
            for (int k = 0; k < 4; k++) begin
                tests_run++;
                if (rid[k] !== k || rs[k] !== k + 1 || rcyc[k] !== 2 * k + 2) begin
                    tests_failed++;
                    $display("FAIL rr_rsp_%0d: got id=%0d s=%0d cyc=%0d required id=%0d s=%0d cyc=%0d",
                             k, rid[k], rs[k], rcyc[k], k, k + 1, 2 * k + 2);
                end
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        req_a[15:8] = 8'd255;
        req_b[15:8] = 8'd255;
        req_mode[1] = 1'b0;
        req_valid[1] = 1'b1;
        #1;
        tests_run++;
        if (req_ready !== 4'b0010) begin tests_failed++; $display("FAIL bp_grant1: got %b required 0010", req_ready); end
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        req_a[31:24] = 8'd5;
        req_b[31:24] = 8'd6;
        req_mode[3] = 1'b0;
        req_valid[3] = 1'b1;
        #1;
        tests_run++;
        if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL bp_exec_ready: got %b required 0000", req_ready); end
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (rsp_valid !== 1'b1 || rsp_s !== 8'd254 || rsp_cout !== 1'b1 || rsp_id !== 2'd1 || req_ready !== 4'b0000) begin
                tests_failed++;
                $display("FAIL bp_hold_%0d: got v=%b s=%0d c=%b id=%0d rdy=%b required v=1 s=254 c=1 id=1 rdy=0000",
                         i, rsp_valid, rsp_s, rsp_cout, rsp_id, req_ready);
            end
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        #1;
        tests_run++;
        if (req_ready !== 4'b1000) begin tests_failed++; $display("FAIL bp_release_grant: got %b required 1000", req_ready); end
        @(posedge clk);
        #1;
        req_valid[3] = 1'b0;
        tests_run++;
        if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_after_ack: got %b required 0", rsp_valid); end
        @(posedge clk);
        #1;
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_s !== 8'd11 || rsp_id !== 2'd3 || rsp_cout !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_next_rsp: got v=%b s=%0d id=%0d c=%b required v=1 s=11 id=3 c=0", rsp_valid, rsp_s, rsp_id, rsp_cout);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_exec();
        req_a[23:16] = 8'd9;
        req_b[23:16] = 8'd9;
        req_mode[2] = 1'b0;
        req_valid[2] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({req_ready, rsp_valid, rsp_id, rsp_s, rsp_cout} !== 16'h0) begin
            tests_failed++;
            $display("FAIL midreset_outputs: got %h required 0", {req_ready, rsp_valid, rsp_id, rsp_s, rsp_cout});
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            tests_run++;
            if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL midreset_no_rsp_%0d: got %b required 0", i, rsp_valid); end
        end
        req_valid = 4'b1010;
        #1;
        tests_run++;
        if (req_ready !== 4'b0010) begin tests_failed++; $display("FAIL midreset_ptr: got %b required 0010", req_ready); end
        req_valid = '0;
        @(posedge clk);
        #1;
    endtask

`ifdef ADDSUB_ARB_OVF_EN
    task automatic test_overflow();
        bit ok;
        do_reset();
        single_op(0, 8'd127, 8'd1, 1'b0, ok);
        tests_run++;
        if (!ok || rsp_s !== 8'd128 || rsp_ovf !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_add: got ok=%b s=%0d ovf=%b required ok=1 s=128 ovf=1", ok, rsp_s, rsp_ovf);
        end
        @(posedge clk);
        #1;
        single_op(1, 8'h89, 8'd3, 1'b1, ok);
        tests_run++;
        if (!ok || rsp_s !== 8'd134 || rsp_ovf !== 1'b0 || rsp_cout !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_sub: got ok=%b s=%0d ovf=%b c=%b required ok=1 s=134 ovf=0 c=1", ok, rsp_s, rsp_ovf, rsp_cout);
        end
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        test_reset();
        test_single_add();
        test_subtract();
        test_round_robin();
        test_backpressure();
        test_reset_mid_exec();
`ifdef ADDSUB_ARB_OVF_EN
        test_overflow();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/addsub_arbiter.md
# addsub_arbiter

Round-robin arbiter and sequencer that shares one `AdderSubtractor_GateLevel` instance among `NREQ` requesters. Each requester uses a valid/ready request channel carrying `A`, `B` and `mode`. The block grants one requester at a time, registers the operands into the shared adder-subtractor and returns `S`/`Cout` tagged with the requester ID on a single valid/ready response channel. It sits between the per-lane control logic and the gate-level datapath.

## Interface
- `N`, 8: operand/result width.
- `NREQ`, 4: number of requesters, ≥2; `IDW = $clog2(NREQ)`.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  request pending, one bit per requester.
- `req_ready`  out  NREQ  one-hot grant; a transfer happens when `req_valid[i] && req_ready[i]`.
- `req_a`, `req_b`  in  NREQ*N  operands; requester i uses bits `[i*N +: N]`.
- `req_mode`  in  NREQ  0 = add, 1 = subtract (A − B, two's complement).
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_id`  out  IDW  index of the requester that owns the result.
- `rsp_s`  out  N  `S` from the shared adder-subtractor.
- `rsp_cout`  out  1  `Cout`. For add it is the carry-out. For subtract, 1 means no borrow (A ≥ B unsigned).

## Operation
- FSM with three states: IDLE, EXEC, RESP.
- IDLE:
  - `req_ready` is asserted, one-hot, for the first requester with `req_valid` set, searching from `ptr` upward modulo NREQ. This is combinational.
  - On a transfer, capture A, B, mode and ID into operand registers, set `ptr` to (granted+1) mod NREQ, and go to EXEC.
  - With no valid request, stay in IDLE.
- EXEC:
  - The operand registers drive the shared instance.
  - At the end of the cycle, capture `S`, `Cout` and the ID into result registers. Go to RESP.
- RESP:
  - `rsp_valid`=1; the result registers stay stable until `rsp_ready`.
  - If `rsp_ready`=0, stay in RESP with `req_ready`=0.
  - If `rsp_ready`=1, the response completes. In the same cycle, grant a pending request under the IDLE rule: on a transfer go to EXEC, otherwise go to IDLE.
- `req_ready` is all-zero in EXEC and in RESP while `rsp_ready`=0.
- Requesters hold `req_valid` and their operands stable until accepted. The grant is recomputed every cycle, so dropping `req_valid` before acceptance is harmless.
- Arithmetic is modulo 2^N with no saturation; `Cout` is passed through unchanged.
- Simultaneous requests resolve by round-robin: the most recently served requester gets lowest priority next.

## Timing
- Reset values:
  - `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_s`=0, `rsp_cout`=0.
  - `ptr`=0, state IDLE, operand registers 0.
- Latency: request accepted in cycle t → `rsp_valid` high in cycle t+2.
- Throughput: one operation per 2 cycles with `rsp_ready` held high (accept during RESP).
- Reset mid-operation clears everything immediately and asynchronously. The in-flight operation is discarded and no response is produced.
- Deassertion of `rst_n` is synchronised externally; the first grant is possible on the first edge after release.

## Configuration
- `ADDSUB_ARB_OVF_EN` defined:
  - Adds output `rsp_ovf` (1 bit, reset 0), registered alongside `rsp_s`.
  - Signed overflow = (A[N-1] == B'[N-1]) && (S[N-1] != A[N-1]), where B' = B ^ {N{mode}}.
- Not defined: the port and its logic are absent; everything else is unchanged.

## Structure
- Package `addsub_arb_pkg` holds:
  - the state encoding constants (IDLE=0, EXEC=1, RESP=2);
  - the default `N`/`NREQ`;
  - the ID-width helper.
- Sub-module `addsub_rr_picker` is combinational: (`req_valid`, `ptr`) → one-hot grant + encoded index.
- The top level holds the FSM, the registers and the single `AdderSubtractor_GateLevel #(N)` instance.

## Test plan
- Single request, requester 0: A=1, B=2, add, `rsp_ready`=1 → `rsp_valid` at t+2, `rsp_s`=3, `rsp_cout`=0, `rsp_id`=0.
- Subtract with borrow, requester 2: A=4, B=10 → `rsp_s`=0xFA, `rsp_cout`=0. Also A=255, B=1 → 254, `rsp_cout`=1. Also A=170, B=170 → 0, `rsp_cout`=1.
- All four requesters valid continuously, each with A=index, B=1, add → grants in order 0,1,2,3,0; one response every 2 cycles; each `rsp_s` equals its index+1.
- Backpressure: A=255, B=255 add, `rsp_ready`=0 for 5 cycles →
  - `rsp_s`=254 and `rsp_cout`=1 held stable;
  - `req_ready`=0 throughout;
  - a grant occurs in the cycle `rsp_ready` rises.
- Reset mid-EXEC: assert `rst_n`=0 one cycle after acceptance → all outputs 0 at once; no response after release; `ptr` restarts at 0.
- With `ADDSUB_ARB_OVF_EN`:
  - A=127, B=1 add → `rsp_s`=128, `rsp_ovf`=1;
  - A=0x89, B=3 subtract → `rsp_s`=134, `rsp_ovf`=0.
